// File: rtl/addr_reg_bank.sv
// addr_reg_bank: DEPTH working address registers with matching shadow
// registers, a single-op-per-cycle update port and a registered read port.
// Reads return the pre-operation value (no bypass). wrap pulses one cycle
// after an INC/DEC/ADD crosses the 0 / all-ones boundary.
// Optional feature: define ADDR_REG_BANK_BOUNDS_EN to add lo_bound/hi_bound
// ports and reject out-of-range results with a one-cycle fault pulse.
module addr_reg_bank #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int SW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [SW-1:0]    op_sel,
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    rd_sel,
`ifdef ADDR_REG_BANK_BOUNDS_EN
  input  logic [WIDTH-1:0] lo_bound,
  input  logic [WIDTH-1:0] hi_bound,
`endif
  output logic [WIDTH-1:0] rd_data,
  output logic             wrap,
  output logic             fault
);

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_LOAD    = 3'b001,
    OP_INC     = 3'b010,
    OP_DEC     = 3'b011,
    OP_ADD     = 3'b100,
    OP_CLR     = 3'b101,
    OP_SAVE    = 3'b110,
    OP_RESTORE = 3'b111
  } op_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [DEPTH-1:0][WIDTH-1:0] r_q, r_d;
  logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0]            rd_data_q, rd_data_d;
  logic                        wrap_q, wrap_d;

  logic [WIDTH-1:0] cur, res;
  logic [WIDTH:0]   sum;
  logic             wr, res_wrap;

`ifdef ADDR_REG_BANK_BOUNDS_EN
  logic fault_q, fault_d;
  logic chk;
`endif

  // Next-state: decode the op against the addressed register, read port
  // samples the current (pre-op) contents.
  always_comb begin
    r_d       = r_q;
    s_d       = s_q;
    rd_data_d = r_q[rd_sel];
    cur       = r_q[op_sel];
    // ADD treats din as a signed offset: crossing happens on carry-out for
    // a non-negative offset, and on absence of carry-out for a negative one.
    sum       = {1'b0, cur} + {1'b0, din};
    res       = cur;
    res_wrap  = 1'b0;
    wr        = 1'b0;
    if (op_valid) begin
      case (op_e'(op))
        OP_LOAD:    begin res = din;              wr = 1'b1; end
        OP_INC:     begin res = cur + ONE;        wr = 1'b1; res_wrap = &cur;  end
        OP_DEC:     begin res = cur - ONE;        wr = 1'b1; res_wrap = ~|cur; end
        OP_ADD:     begin
          res      = sum[WIDTH-1:0];
          wr       = 1'b1;
          res_wrap = din[WIDTH-1] ? ~sum[WIDTH] : sum[WIDTH];
        end
        OP_CLR:     begin res = '0;               wr = 1'b1; end
        OP_SAVE:    s_d[op_sel] = cur;
        OP_RESTORE: begin res = s_q[op_sel];      wr = 1'b1; end
        default:    ;
      endcase
    end
`ifdef ADDR_REG_BANK_BOUNDS_EN
    // CLR is deliberately exempt so software can always park a register at 0.
    fault_d = 1'b0;
    chk = op_valid && (op != OP_NOP) && (op != OP_CLR) && (op != OP_SAVE);
    if (chk && ((res < lo_bound) || (res > hi_bound))) begin
      fault_d  = 1'b1;
      wr       = 1'b0;
      res_wrap = 1'b0;
    end
`endif
    if (wr) r_d[op_sel] = res;
    wrap_d = res_wrap;
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      s_q       <= '0;
      rd_data_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      r_q       <= r_d;
      s_q       <= s_d;
      rd_data_q <= rd_data_d;
      wrap_q    <= wrap_d;
    end
  end

`ifdef ADDR_REG_BANK_BOUNDS_EN
  // Fault pulse flop, only present when bounds checking is built in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign rd_data = rd_data_q;
  assign wrap    = wrap_q;

endmodule
